// File: rtl/multicycle_fsm.sv
// Multi-cycle processor control FSM (Moore) with an FPU handshake that aborts after a bounded wait.
// The timeout abort sets a sticky FPUTimeout flag.
module multicycle_fsm #(
  parameter int FPU_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       FPUDone,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       FPUStart,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       FPUTimeout,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FPUISSUE = 4'd10,
    FPUWAIT  = 4'd11,
    FPUWB    = 4'd12
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(FPU_TIMEOUT - 1);

  // The register is a raw 4-bit code so that the unused codes 13-15 can be held and recovered from.
  logic [3:0] state;
  state_t     next_state;
  logic [7:0] waitcnt;
  logic       timeout_q;
  logic       timeout_hit;
  logic       unused_funct;

  assign unused_funct = ^Funct[4:1];
  assign timeout_hit  = (state == FPUWAIT) && !FPUDone && (waitcnt == LAST_WAIT);
  assign FPUTimeout   = timeout_q;
  assign State        = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      waitcnt   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == FPUISSUE)
        waitcnt <= 8'd0;
      else if (state == FPUWAIT && !FPUDone)
        waitcnt <= waitcnt + 8'd1;
      if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end

  always_comb begin
    next_state = FETCH;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    NextPC     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    ALUOp      = 1'b0;
    FPUStart   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        NextPC     = 1'b1;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_state = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          2'b11:   next_state = FPUISSUE;
          default: next_state = Funct[5] ? EXECUTEI : EXECUTER;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        next_state = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        ALUOp      = 1'b1;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUOp      = 1'b1;
        next_state = ALUWB;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      FPUISSUE: begin
        FPUStart   = 1'b1;
        next_state = FPUWAIT;
      end
      // A result arriving on the last allowed wait cycle still beats the abort.
      FPUWAIT: begin
        if (FPUDone)
          next_state = FPUWB;
        else if (waitcnt == LAST_WAIT)
          next_state = FETCH;
        else
          next_state = FPUWAIT;
      end
      FPUWB: begin
        ResultSrc = 2'b11;
        RegW      = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_fsm.sv
// Self-checking bench for multicycle_fsm: directed vector table, FPU corner sequences,
// and random instructions checked against an instruction-level reference model.
module tb_multicycle_fsm;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FPUDone;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, FPUStart;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic       FPUTimeout;
  logic [3:0] State;
  logic [13:0] act_outs;

  int passed = 0;
  int total  = 0;
  logic exp_tmo = 1'b0;
  bit   expect_timeout;
  logic [3:0] expq[$];

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    int          done_at;
    int          len;
    logic [31:0] seq;
  } vec_t;

  vec_t vecs[8];

  multicycle_fsm #(.FPU_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .FPUDone(FPUDone),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .FPUStart(FPUStart), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .FPUTimeout(FPUTimeout), .State(State)
  );

  always #5 clk = ~clk;

  assign act_outs = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, FPUStart,
                     ALUSrcA, ALUSrcB, ResultSrc};

  // Output table per state code, packed in the same order as act_outs.
  function automatic logic [13:0] specOuts(input logic [3:0] code);
    logic irw, adr, npc, regw, memw, br, aluop, fst;
    logic [1:0] sa, sb, rs;
    {irw, adr, npc, regw, memw, br, aluop, fst} = 8'd0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (code)
      4'd0:  begin irw = 1'b1; npc = 1'b1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd1:  begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      4'd2:  sb = 2'b01;
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; regw = 1'b1; end
      4'd5:  begin adr = 1'b1; memw = 1'b1; end
      4'd6:  aluop = 1'b1;
      4'd7:  begin sb = 2'b01; aluop = 1'b1; end
      4'd8:  regw = 1'b1;
      4'd9:  begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1'b1; end
      4'd10: fst = 1'b1;
      4'd12: begin rs = 2'b11; regw = 1'b1; end
      default: ;
    endcase
    return {irw, adr, npc, regw, memw, br, aluop, fst, sa, sb, rs};
  endfunction

  // Instruction-level model: the state trace one instruction walks through, from its FETCH.
  function automatic void buildExpected(input logic [1:0] op, input logic [5:0] funct,
                                        input int done_at);
    expq.delete();
    expect_timeout = 1'b0;
    expq.push_back(4'd0);
    expq.push_back(4'd1);
    case (op)
      2'b00: begin
        expq.push_back(funct[5] ? 4'd7 : 4'd6);
        expq.push_back(4'd8);
      end
      2'b01: begin
        expq.push_back(4'd2);
        if (funct[0]) begin
          expq.push_back(4'd3);
          expq.push_back(4'd4);
        end else begin
          expq.push_back(4'd5);
        end
      end
      2'b10: expq.push_back(4'd9);
      default: begin
        expq.push_back(4'd10);
        if (done_at >= 1 && done_at <= T) begin
          repeat (done_at) expq.push_back(4'd11);
          expq.push_back(4'd12);
        end else begin
          repeat (T) expq.push_back(4'd11);
          expect_timeout = 1'b1;
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  // Entered and left at a negedge where the DUT sits in FETCH.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                               input int done_at, input bit noise);
    int waits;
    waits = 0;
    Op    = op;
    Funct = funct;
    foreach (expq[i]) begin
      checkOutput("state", 32'(State), 32'(expq[i]));
      checkOutput("strobes", 32'(act_outs), 32'(specOuts(expq[i])));
      checkOutput("timeout_flag", 32'(FPUTimeout), 32'(exp_tmo));
      FPUDone = 1'b0;
      if (expq[i] == 4'd11) begin
        waits++;
        if (waits == done_at) FPUDone = 1'b1;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        FPUDone = 1'b1;
      end
      @(negedge clk);
    end
    FPUDone = 1'b0;
    if (expect_timeout) exp_tmo = 1'b1;
  endtask

  task automatic resetDut();
    reset   = 1'b0;
    FPUDone = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", 32'(State), 32'd0);
    checkOutput("reset_strobes", 32'(act_outs), 32'(specOuts(4'd0)));
    checkOutput("reset_timeout", 32'(FPUTimeout), 32'd0);
    reset   = 1'b1;
    exp_tmo = 1'b0;
  endtask

  initial begin
    logic [3:0] pre[4];
    logic [1:0] rop;
    logic [5:0] rfunct;
    int         rdone;

    vecs[0] = '{2'b00, 6'b000000, 0, 4, 32'h0000_8610};
    vecs[1] = '{2'b00, 6'b100000, 0, 4, 32'h0000_8710};
    vecs[2] = '{2'b01, 6'b000001, 0, 5, 32'h0004_3210};
    vecs[3] = '{2'b01, 6'b000000, 0, 4, 32'h0000_5210};
    vecs[4] = '{2'b10, 6'b000000, 0, 3, 32'h0000_0910};
    vecs[5] = '{2'b11, 6'b000000, 3, 7, 32'h0CBB_BA10};
    vecs[6] = '{2'b01, 6'b100001, 0, 5, 32'h0004_3210};
    vecs[7] = '{2'b11, 6'b000000, 1, 5, 32'h000C_BA10};

    reset = 1'b0; Op = 2'b00; Funct = 6'd0; FPUDone = 1'b0;
    resetDut();

    for (int v = 0; v < 8; v++) begin
      expq.delete();
      expect_timeout = 1'b0;
      for (int k = 0; k < vecs[v].len; k++) expq.push_back(vecs[v].seq[4*k +: 4]);
      applyStimulus(vecs[v].op, vecs[v].funct, vecs[v].done_at, 1'b0);
    end

    // FPU never answers: full-length wait, abort, sticky flag seen by later instructions.
    buildExpected(2'b11, 6'd0, 0);
    applyStimulus(2'b11, 6'd0, 0, 1'b0);
    buildExpected(2'b00, 6'd0, 0);
    applyStimulus(2'b00, 6'd0, 0, 1'b0);
    buildExpected(2'b10, 6'd0, 0);
    applyStimulus(2'b10, 6'd0, 0, 1'b0);

    // Result on the final allowed wait cycle wins over the abort.
    resetDut();
    buildExpected(2'b11, 6'd0, T);
    applyStimulus(2'b11, 6'd0, T, 1'b0);
    buildExpected(2'b00, 6'd0, 0);
    applyStimulus(2'b00, 6'd0, 0, 1'b0);

    // Reset during FPUWAIT discards the in-flight result and clears the sticky flag.
    buildExpected(2'b11, 6'd0, 0);
    applyStimulus(2'b11, 6'd0, 0, 1'b0);
    pre = '{4'd0, 4'd1, 4'd10, 4'd11};
    Op = 2'b11; Funct = 6'd0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("abort_seq_state", 32'(State), 32'(pre[k]));
      @(negedge clk);
    end
    checkOutput("abort_in_wait", 32'(State), 32'd11);
    reset   = 1'b0;
    FPUDone = 1'b1;
    @(negedge clk);
    checkOutput("abort_state", 32'(State), 32'd0);
    checkOutput("abort_timeout", 32'(FPUTimeout), 32'd0);
    checkOutput("abort_regw", 32'(RegW), 32'd0);
    reset   = 1'b1;
    FPUDone = 1'b0;
    exp_tmo = 1'b0;
    buildExpected(2'b01, 6'd1, 0);
    applyStimulus(2'b01, 6'd1, 0, 1'b0);

    // Illegal code recovers to FETCH with every strobe low while it is held.
    force dut.state = 4'd14;
    #1;
    checkOutput("illegal_state", 32'(State), 32'd14);
    checkOutput("illegal_strobes", 32'(act_outs), 32'd0);
    release dut.state;
    @(negedge clk);
    checkOutput("illegal_recover", 32'(State), 32'd0);
    checkOutput("illegal_recover_strobes", 32'(act_outs), 32'(specOuts(4'd0)));
    buildExpected(2'b00, 6'b100000, 0);
    applyStimulus(2'b00, 6'b100000, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) resetDut();
      rop    = 2'($urandom_range(0, 3));
      rfunct = 6'($urandom);
      rdone  = $urandom_range(0, 20);
      buildExpected(rop, rfunct, rdone);
      applyStimulus(rop, rfunct, rdone, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
